// File: rtl/alu_pkg.sv
// Shared types for alu_pipe: op codes, FSM states and the registered flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_NAND = 4'd6,
    OP_NOTA = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one partial product per cycle, WIDTH cycles per product.
// Only compiled when ALU_PIPE_MUL_EN is defined.
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_d;

  // The final partial product is folded in combinationally so the top can
  // capture the full product on the edge that ends the last busy cycle.
  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_pipe.sv
// Single-stage registered ALU with valid/ready handshakes on both sides.
// Define ALU_PIPE_MUL_EN to enable op 10 (MUL) via alu_mul_seq; otherwise op 10 is illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);
  state_e             state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  flags_t             flags_q;
  logic [WIDTH-1:0]   res_d;
  flags_t             flags_d;
  flags_t             mul_flags_d;
  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};

`ifdef ALU_PIPE_MUL_EN
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_prod  = '0;
`endif

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    case (op)
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_ADD: begin
        res_d         = sum[WIDTH-1:0];
        flags_d.carry = sum[WIDTH];
        flags_d.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d         = diff[WIDTH-1:0];
        flags_d.carry = diff[WIDTH];
        flags_d.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  res_d = a ^ b;
      OP_NOR:  res_d = ~(a | b);
      OP_NAND: res_d = ~(a & b);
      OP_NOTA: res_d = ~a;
      OP_SHL:  res_d = a << b[SHW-1:0];
      OP_SHR:  res_d = a >> b[SHW-1:0];
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  res_d = '0;
`endif
      default: flags_d.err = 1'b1;
    endcase
    flags_d.zero = (res_d == '0);
    flags_d.neg  = res_d[WIDTH-1];
  end

  always_comb begin
    mul_flags_d       = '0;
    mul_flags_d.zero  = (mul_prod[WIDTH-1:0] == '0);
    mul_flags_d.neg   = mul_prod[WIDTH-1];
    mul_flags_d.carry = |mul_prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && mul_start) begin
            state_q     <= S_MUL_BUSY;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            result_q    <= res_d;
            flags_q     <= flags_d;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_MUL_BUSY: begin
          if (mul_done) begin
            state_q     <= S_IDLE;
            result_q    <= mul_prod[WIDTH-1:0];
            flags_q     <= mul_flags_d;
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;
  assign err       = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8) against an arithmetic reference model.
// Expectations for op 10 follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] res;
    logic       zero;
    logic       neg;
    logic       carry;
    logic       ovf;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero, neg, carry, ovf, err;

  int checks   = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end

  function automatic exp_t observed();
    return {result, zero, neg, carry, ovf, err};
  endfunction

  // Reference model built from plain integer arithmetic on the op semantics.
  function automatic exp_t model(input int opc, input int x, input int y);
    exp_t e;
    int   full, sx, sy, sr;
    bit   ill;
    e    = '0;
    full = 0;
    sr   = 0;
    ill  = 1'b0;
    sx   = (x > 127) ? x - 256 : x;
    sy   = (y > 127) ? y - 256 : y;
    case (opc)
      0: full = x & y;
      1: full = x | y;
      2: begin
        full    = x + y;
        e.carry = (full > 255);
        sr      = sx + sy;
        e.ovf   = (sr > 127) || (sr < -128);
      end
      3: begin
        full    = x - y;
        e.carry = (x < y);
        sr      = sx - sy;
        e.ovf   = (sr > 127) || (sr < -128);
      end
      4: full = x ^ y;
      5: full = ~(x | y);
      6: full = ~(x & y);
      7: full = ~x;
      8: full = x << (y % 8);
      9: full = x >> (y % 8);
`ifdef ALU_PIPE_MUL_EN
      10: begin
        full    = x * y;
        e.carry = (full > 255);
      end
`endif
      default: ill = 1'b1;
    endcase
    e.res  = ill ? 8'h00 : 8'(full & 255);
    e.err  = ill;
    e.zero = (e.res == 8'h00);
    e.neg  = e.res[7];
    return e;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    a         = 8'h00;
    b         = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h00 || {zero, neg, carry, ovf, err} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b result=%h flags=%b required 0/00/00000",
               out_valid, result, {zero, neg, carry, ovf, err});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    exp_t ex;
    @(negedge clk);
    out_ready = 1'b1;
    op = 4'd2; a = 8'h7F; b = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    ex = '{res: 8'h80, zero: 1'b0, neg: 1'b1, carry: 1'b0, ovf: 1'b1, err: 1'b0};
    checks++;
    if (out_valid !== 1'b1 || observed() !== ex) begin
      failures++;
      $display("FAIL add_7f_01: valid=%b got %h required %h", out_valid, observed(), ex);
    end
    op = 4'd3; a = 8'h05; b = 8'h05;
    @(negedge clk);
    ex = '{res: 8'h00, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0, err: 1'b0};
    checks++;
    if (out_valid !== 1'b1 || observed() !== ex) begin
      failures++;
      $display("FAIL sub_05_05: valid=%b got %h required %h", out_valid, observed(), ex);
    end
    op = 4'd3; a = 8'h03; b = 8'h05;
    @(negedge clk);
    in_valid = 1'b0;
    ex = '{res: 8'hFE, zero: 1'b0, neg: 1'b1, carry: 1'b1, ovf: 1'b0, err: 1'b0};
    checks++;
    if (out_valid !== 1'b1 || observed() !== ex) begin
      failures++;
      $display("FAIL sub_03_05: valid=%b got %h required %h", out_valid, observed(), ex);
    end
  endtask

  task automatic test_back_to_back();
    exp_t prev;
    int   opc;
    prev = '0;
    out_ready = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || observed() !== prev) begin
          failures++;
          $display("FAIL b2b_result[%0d]: valid=%b got %h required %h", i, out_valid, observed(), prev);
        end
      end
      if (i < 40) begin
        opc = $urandom_range(0, 14);
        if (opc >= 10) opc++;
        op = opc[3:0];
        a  = 8'($urandom);
        b  = 8'($urandom);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready[%0d]: in_ready=%b required 1", i, in_ready);
        end
        prev = model(opc, int'(a), int'(b));
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_mul();
    exp_t ex;
    logic [7:0] ma [6];
    logic [7:0] mb [6];
    ma[0] = 8'h12; mb[0] = 8'h10;
    ma[1] = 8'hFF; mb[1] = 8'hFF;
    ma[2] = 8'h00; mb[2] = 8'h9C;
    for (int k = 3; k < 6; k++) begin
      ma[k] = 8'($urandom);
      mb[k] = 8'($urandom);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      op = 4'd10; a = ma[k]; b = mb[k]; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL mul_accept[%0d]: in_ready=%b required 1", k, in_ready);
      end
`ifdef ALU_PIPE_MUL_EN
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL mul_busy[%0d] cycle %0d: in_ready=%b out_valid=%b required 0/0",
                   k, c, in_ready, out_valid);
        end
      end
`endif
      @(negedge clk);
      in_valid = 1'b0;
      ex = model(10, int'(ma[k]), int'(mb[k]));
      checks++;
      if (out_valid !== 1'b1 || observed() !== ex) begin
        failures++;
        $display("FAIL mul_result[%0d] %h*%h: valid=%b got %h required %h",
                 k, ma[k], mb[k], out_valid, observed(), ex);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mul_consumed[%0d]: out_valid=%b required 0", k, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t ex_xor, ex_and;
    ex_xor = '{res: 8'h0F, zero: 1'b0, neg: 1'b0, carry: 1'b0, ovf: 1'b0, err: 1'b0};
    ex_and = '{res: 8'h0C, zero: 1'b0, neg: 1'b0, carry: 1'b0, ovf: 1'b0, err: 1'b0};
    @(negedge clk);
    out_ready = 1'b0;
    op = 4'd4; a = 8'hF0; b = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    op = 4'd0; a = 8'h3C; b = 8'h0F;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== ex_xor) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b got %h required 1/0/%h",
                 c, out_valid, in_ready, observed(), ex_xor);
      end
      if (c < 4) @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || observed() !== ex_xor) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b got %h required 1/%h", in_ready, observed(), ex_xor);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || observed() !== ex_and) begin
      failures++;
      $display("FAIL bp_replace: valid=%b got %h required 1/%h", out_valid, observed(), ex_and);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_single_transfer: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_random_flow();
    exp_t sb[$];
    exp_t e;
    int   opc;
    bit   acc, xfer;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      opc       = $urandom_range(0, 15);
      op        = opc[3:0];
      a         = 8'($urandom);
      b         = 8'($urandom);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL flow_spurious[%0d]: result %h presented, required nothing pending", i, result);
        end else begin
          e = sb.pop_front();
          if (observed() !== e) begin
            failures++;
            $display("FAIL flow_result[%0d]: got %h required %h", i, observed(), e);
          end
        end
      end
      if (acc) sb.push_back(model(opc, int'(a), int'(b)));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
          failures++;
          $display("FAIL flow_drain: got %h required %h", observed(), e);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL flow_drain_timeout: %0d results pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mul();
    exp_t ex;
    bit   seen;
    @(negedge clk);
    out_ready = 1'b1;
    op = 4'd1; a = 8'h81; b = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    op = 4'd10; a = 8'h55; b = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h00 || {zero, neg, carry, ovf, err} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_abort_async: out_valid=%b result=%h flags=%b required 0/00/00000",
               out_valid, result, {zero, neg, carry, ovf, err});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_no_result: out_valid seen=%b required 0", seen);
    end
    op = 4'd12; a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ex = '{res: 8'h00, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0, err: 1'b1};
    checks++;
    if (out_valid !== 1'b1 || observed() !== ex) begin
      failures++;
      $display("FAIL illegal_op12: valid=%b got %h required 1/%h", out_valid, observed(), ex);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_random_flow();
    test_reset_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width, derived, not overridden.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 op  input  4  operation code (see REQ-013).
REQ-009 out_valid  output  1  result registers hold an unconsumed result.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero, neg, carry, ovf, err  output  1 each  registered flags accompanying result.

Function
REQ-013 op codes SHALL be: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 NAND, 7 NOT a, 8 SHL a by b[SHW-1:0], 9 SHR logical, 10 MUL; 11-15 illegal.
REQ-014 Transfer occurs when in_valid && in_ready; out-transfer when out_valid && out_ready.
REQ-015 in_ready SHALL be combinational: 1 iff state==IDLE && (!out_valid || out_ready).
REQ-016 FSM states SHALL be IDLE, MUL_BUSY; only an accepted MUL leaves IDLE.
REQ-017 Non-MUL ops: result and flags registered on the accepting edge; out_valid 1 the next cycle (latency 1); back-to-back accepts at full throughput when out_ready high.
REQ-018 MUL: shift-add, one partial product per cycle, exactly WIDTH cycles in MUL_BUSY, then result loaded and out_valid set (latency WIDTH+1); in_ready 0 throughout.
REQ-019 result SHALL be the low WIDTH bits of the operation; ADD/SUB wrap modulo 2^WIDTH.
REQ-020 zero = (result==0); neg = result[WIDTH-1] for all ops.
REQ-021 carry = carry-out for ADD, borrow (a<b unsigned) for SUB, any nonzero upper product bit for MUL, 0 otherwise.
REQ-022 ovf = signed two's-complement overflow for ADD/SUB, 0 otherwise.
REQ-023 Illegal op: accepted with latency 1, result 0, zero 1, err 1; err 0 for all legal ops.
REQ-024 While out_valid && !out_ready, result and flags SHALL hold stable.
REQ-025 Simultaneous out-transfer and new accept in the same cycle: new result replaces old, out_valid stays 1.

Reset
REQ-026 rst_n low SHALL force state IDLE, out_valid 0, result 0, all flags 0, MUL datapath registers 0, immediately and independent of clk.
REQ-027 Reset during MUL_BUSY SHALL abort the multiply; no result emitted after release.
REQ-028 After release, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-029 Macro ALU_PIPE_MUL_EN: defined -> MUL per REQ-018 with sub-module instantiated; undefined -> op 10 treated as illegal per REQ-023, MUL_BUSY unreachable, no multiplier logic synthesised.

Structure
REQ-030 Package alu_pkg SHALL hold the op-code enumeration, FSM state enumeration and flag-bundle typedef.
REQ-031 Sub-module alu_mul_seq SHALL hold the iterative multiplier (start, a, b in; done, product 2*WIDTH out); compiled only under ALU_PIPE_MUL_EN.

Verification (WIDTH=8)
REQ-032 ADD a=0x7F b=0x01 -> next cycle result 0x80, neg 1, ovf 1, carry 0, zero 0.
REQ-033 SUB a=0x05 b=0x05 then a=0x03 b=0x05 -> 0x00 zero 1 carry 0; then 0xFE carry 1 neg 1.
REQ-034 MUL a=0x12 b=0x10 (MUL_EN) -> in_ready 0 for 8 cycles, result 0x20 carry 1 at cycle 9; without MUL_EN -> result 0 err 1 at cycle 1.
REQ-035 XOR 0xF0/0xFF with out_ready held 0 for 5 cycles -> result 0x0F stable, in_ready 0, single transfer on release.
REQ-036 Assert rst_n low 3 cycles into MUL -> out_valid 0 at once, no result after release, in_ready 1 first cycle after; op 12 -> err 1 result 0.
